freelist_ctrl: RTL and testbench
================================

# freelist_ctrl

Allocation controller for the physical-register free list in the 2-way dispatch path. Tracks the free-register count, grants or stalls both dispatch slots all-or-nothing, forwards retire frees, and sequences branch-squash recovery (rollback pulse, then a drain window). Sits between dispatch/ROB and the free list; it drives every free-list control input.

## Interface
Parameters:
- FL_SIZE, 32, free-list entries.
- PREG_IDX_WIDTH, 6, physical register index width.
- RECOVER_CYCLES, 2, dispatch-stall cycles after the rollback pulse (≥1).

Ports:
- clock  in  1  single clock.
- reset  in  1  asynchronous, active-low reset.
- dp_req0, dp_req1  in  1  dispatch slot needs a new preg.
- dp_hold  in  1  downstream (RS/ROB) stall; blocks allocation.
- rt_free0, rt_free1  in  1  retire slot frees a preg.
- rt_preg0, rt_preg1  in  PREG_IDX_WIDTH  preg being freed.
- squash  in  1  mispredict flush from ROB.
- fl_rd_en0, fl_rd_en1  out  1  free-list pop enables.
- fl_wr_en0, fl_wr_en1  out  1  free-list push enables.
- fl_din0, fl_din1  out  PREG_IDX_WIDTH  pushed preg indices.
- fl_dp_stall  out  1  free-list stall input.
- fl_rollback_en  out  1  free-list rollback pulse.
- dp_stall  out  1  stall to dispatch.
- free_cnt  out  $clog2(FL_SIZE+1)  registered free-register count.
- recovering  out  1  high in FLUSH or DRAIN.
- ovf_err  out  1  sticky: free count would exceed FL_SIZE.

## Operation
- States: RUN, FLUSH, DRAIN. Reset → RUN.
- need = dp_req0 + dp_req1. In RUN with !squash, grant iff !dp_hold and free_cnt ≥ need; otherwise dp_stall=1. No partial grant: slot1 never granted without slot0 when both request.
- Grant: fl_rd_en0=dp_req0, fl_rd_en1=dp_req1, fl_dp_stall=0. No grant: fl_dp_stall=1 (rd_en may still mirror requests, since the free list gates on fl_dp_stall).
- Frees pass through combinationally: fl_wr_en0/1=rt_free0/1, fl_din0/1=rt_preg0/1. Frees never satisfy a same-cycle request (no bypass).
- free_cnt_next = free_cnt − granted + freed, computed at width+1. If result > FL_SIZE, clamp to FL_SIZE and set ovf_err (cleared only by reset).
- squash in any state: dispatch stall and no grant that cycle; next state FLUSH.
- FLUSH (1 cycle): fl_rollback_en=1, fl_wr_en0/1=0, dp_stall=1, free_cnt ← FL_SIZE; next DRAIN with drain counter ← RECOVER_CYCLES−1.
- DRAIN: dp_stall=1, frees pass through with saturation, no grants; counter decrements; at 0 → RUN. squash in DRAIN or FLUSH → FLUSH again.
- recovering = (state != RUN).

## Timing
- Reset values: state RUN, free_cnt=FL_SIZE, ovf_err=0, drain counter 0; all fl_* enables 0, dp_stall=0 (unless squash), fl_rollback_en=0.
- Grant decision and stall are combinational from registered free_cnt/state plus inputs; zero-cycle latency.
- free_cnt updates on the clock edge after grant/free.
- squash at cycle t → rollback pulse at t+1 → dispatch resumes at t+2+RECOVER_CYCLES... specifically first grant possible at t+1+RECOVER_CYCLES+1.
- Reset asserted mid-recovery returns to RUN immediately (async).
- free_cnt=1, need=2 → stall both; free_cnt=0, need=0 → no stall.

## Configuration
- FL_CTRL_PERF_EN defined: adds outputs stall_cyc (32-bit, counts cycles with dp_stall=1 and need>0) and rollback_cnt (16-bit, counts FLUSH entries); both wrap, reset to 0.
- Undefined: ports and counters absent; all other behaviour identical.

## Test plan
- Reset low then high → free_cnt=32, dp_stall=0, all fl_* enables 0, ovf_err=0.
- 16 cycles dp_req0=dp_req1=1, no frees → free_cnt reaches 0, then dp_stall=1, fl_dp_stall=1.
- free_cnt=1, dp_req0=dp_req1=1, rt_free0=1 → stall both; next cycle free_cnt=2, grant both, then free_cnt=0.
- squash at t with dp_req0=1 → no grant at t, fl_rollback_en=1 only at t+1, free_cnt=32 at t+2, dp_stall=1 through DRAIN, grant resumes after RECOVER_CYCLES=2.
- free_cnt=32 with rt_free0=1 → free_cnt stays 32, ovf_err=1 and stays set.
- dp_hold=1, free_cnt=10, both requests → dp_stall=1, free_cnt unchanged.

Source files
------------

// File: rtl/freelist_ctrl_if.sv
// Dispatch/retire/squash handshake between the ROB-side driver and freelist_ctrl,
// plus the free-list control outputs the controller produces.
interface freelist_ctrl_if #(
  parameter int unsigned FL_SIZE        = 32,
  parameter int unsigned PREG_IDX_WIDTH = 6
);
  localparam int unsigned CntW = $clog2(FL_SIZE + 1);

  logic                      dp_req0;
  logic                      dp_req1;
  logic                      dp_hold;
  logic                      rt_free0;
  logic                      rt_free1;
  logic [PREG_IDX_WIDTH-1:0] rt_preg0;
  logic [PREG_IDX_WIDTH-1:0] rt_preg1;
  logic                      squash;

  logic                      fl_rd_en0;
  logic                      fl_rd_en1;
  logic                      fl_wr_en0;
  logic                      fl_wr_en1;
  logic [PREG_IDX_WIDTH-1:0] fl_din0;
  logic [PREG_IDX_WIDTH-1:0] fl_din1;
  logic                      fl_dp_stall;
  logic                      fl_rollback_en;
  logic                      dp_stall;
  logic [CntW-1:0]           free_cnt;
  logic                      recovering;
  logic                      ovf_err;

  modport master (
    output dp_req0, dp_req1, dp_hold, rt_free0, rt_free1, rt_preg0, rt_preg1, squash,
    input  fl_rd_en0, fl_rd_en1, fl_wr_en0, fl_wr_en1, fl_din0, fl_din1, fl_dp_stall,
           fl_rollback_en, dp_stall, free_cnt, recovering, ovf_err
  );

  modport slave (
    input  dp_req0, dp_req1, dp_hold, rt_free0, rt_free1, rt_preg0, rt_preg1, squash,
    output fl_rd_en0, fl_rd_en1, fl_wr_en0, fl_wr_en1, fl_din0, fl_din1, fl_dp_stall,
           fl_rollback_en, dp_stall, free_cnt, recovering, ovf_err
  );
endinterface

// File: rtl/freelist_ctrl.sv
// Free-list allocation controller: all-or-nothing 2-way grant, retire free pass-through,
// squash recovery (FLUSH rollback pulse then DRAIN). FL_CTRL_PERF_EN adds perf counters.
module freelist_ctrl #(
  parameter int unsigned FL_SIZE        = 32,
  parameter int unsigned PREG_IDX_WIDTH = 6,
  parameter int unsigned RECOVER_CYCLES = 2
) (
  input logic           clock,
  input logic           reset,
  freelist_ctrl_if.slave fl_if
`ifdef FL_CTRL_PERF_EN
  ,
  output logic [31:0]   stall_cyc,
  output logic [15:0]   rollback_cnt
`endif
);

  localparam int unsigned CntW   = $clog2(FL_SIZE + 1);
  localparam int unsigned SumW   = CntW + 1;
  localparam int unsigned DrainW = (RECOVER_CYCLES > 1) ? $clog2(RECOVER_CYCLES) : 1;
  localparam logic [SumW-1:0]   FlFull    = SumW'(FL_SIZE);
  localparam logic [DrainW-1:0] DrainInit = DrainW'(RECOVER_CYCLES - 1);

  typedef enum logic [1:0] {StRun, StFlush, StDrain} state_e;

  state_e            state_q;
  logic [CntW-1:0]   free_cnt_q, free_cnt_d;
  logic [DrainW-1:0] drain_cnt_q;
  logic              ovf_err_q;
  logic              ovf_set;
  logic [1:0]        need;
  logic [1:0]        freed;
  logic              grant;
  logic              wr_ok;
  logic [SumW-1:0]   cnt_sum;

  always_comb begin
    need  = {1'b0, fl_if.dp_req0} + {1'b0, fl_if.dp_req1};
    // The free list is being restored during FLUSH, so retire pushes are dropped then.
    wr_ok = (state_q != StFlush);
    freed = wr_ok ? ({1'b0, fl_if.rt_free0} + {1'b0, fl_if.rt_free1}) : 2'd0;
    grant = (state_q == StRun) && !fl_if.squash && !fl_if.dp_hold &&
            (free_cnt_q >= CntW'(need));
    // Grant only when free_cnt_q >= need, so the subtraction cannot underflow.
    cnt_sum    = {1'b0, free_cnt_q} - (grant ? SumW'(need) : '0) + SumW'(freed);
    ovf_set    = 1'b0;
    free_cnt_d = cnt_sum[CntW-1:0];
    if (cnt_sum > FlFull) begin
      ovf_set    = 1'b1;
      free_cnt_d = CntW'(FL_SIZE);
    end
  end

  assign fl_if.fl_rd_en0      = fl_if.dp_req0 & grant;
  assign fl_if.fl_rd_en1      = fl_if.dp_req1 & grant;
  assign fl_if.fl_wr_en0      = fl_if.rt_free0 & wr_ok;
  assign fl_if.fl_wr_en1      = fl_if.rt_free1 & wr_ok;
  assign fl_if.fl_din0        = fl_if.rt_preg0;
  assign fl_if.fl_din1        = fl_if.rt_preg1;
  assign fl_if.fl_dp_stall    = !grant;
  assign fl_if.dp_stall       = !grant;
  assign fl_if.fl_rollback_en = (state_q == StFlush);
  assign fl_if.free_cnt       = free_cnt_q;
  assign fl_if.recovering     = (state_q != StRun);
  assign fl_if.ovf_err        = ovf_err_q;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q     <= StRun;
      free_cnt_q  <= CntW'(FL_SIZE);
      drain_cnt_q <= '0;
      ovf_err_q   <= 1'b0;
    end else begin
      if (ovf_set) ovf_err_q <= 1'b1;
      case (state_q)
        StRun: free_cnt_q <= free_cnt_d;
        StFlush: begin
          free_cnt_q  <= CntW'(FL_SIZE);
          drain_cnt_q <= DrainInit;
          state_q     <= StDrain;
        end
        StDrain: begin
          free_cnt_q <= free_cnt_d;
          if (drain_cnt_q == '0) state_q <= StRun;
          else                   drain_cnt_q <= drain_cnt_q - 1'b1;
        end
        default: state_q <= StRun;
      endcase
      // Squash overrides any other transition, including from FLUSH and DRAIN.
      if (fl_if.squash) state_q <= StFlush;
    end
  end

`ifdef FL_CTRL_PERF_EN
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      stall_cyc    <= '0;
      rollback_cnt <= '0;
    end else begin
      if (!grant && (need != 2'd0)) stall_cyc <= stall_cyc + 32'd1;
      if (fl_if.squash)             rollback_cnt <= rollback_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_freelist_ctrl.sv
// Directed self-checking bench for freelist_ctrl (default build, RECOVER_CYCLES = 2).
module tb_freelist_ctrl;

  logic clock;
  logic reset;
  int   checks;
  int   errors;

  freelist_ctrl_if #(.FL_SIZE(32), .PREG_IDX_WIDTH(6)) fl_if ();

`ifdef FL_CTRL_PERF_EN
  logic [31:0] stall_cyc;
  logic [15:0] rollback_cnt;
`endif

  freelist_ctrl #(
    .FL_SIZE       (32),
    .PREG_IDX_WIDTH(6),
    .RECOVER_CYCLES(2)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .fl_if       (fl_if)
`ifdef FL_CTRL_PERF_EN
    ,
    .stall_cyc   (stall_cyc),
    .rollback_cnt(rollback_cnt)
`endif
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Inputs change 1 time unit after the rising edge; outputs are read 2 units later.
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic drive(input logic r0, input logic r1, input logic hold, input logic f0,
                       input logic f1, input logic [5:0] p0, input logic [5:0] p1,
                       input logic sq);
    fl_if.dp_req0  = r0;
    fl_if.dp_req1  = r1;
    fl_if.dp_hold  = hold;
    fl_if.rt_free0 = f0;
    fl_if.rt_free1 = f1;
    fl_if.rt_preg0 = p0;
    fl_if.rt_preg1 = p1;
    fl_if.squash   = sq;
    #2;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    drive(0, 0, 0, 0, 0, 6'd0, 6'd0, 0);
    tick();
    tick();
    reset = 1'b1;
    #2;
    checks++;
    if (fl_if.free_cnt !== 6'd32) begin
      errors++; $display("FAIL reset_free_cnt got %0d want 32", fl_if.free_cnt);
    end
    checks++;
    if (fl_if.dp_stall !== 1'b0) begin
      errors++; $display("FAIL reset_dp_stall got %b want 0", fl_if.dp_stall);
    end
    checks++;
    if ({fl_if.fl_rd_en0, fl_if.fl_rd_en1, fl_if.fl_wr_en0, fl_if.fl_wr_en1,
         fl_if.fl_rollback_en} !== 5'b0) begin
      errors++; $display("FAIL reset_fl_enables got %b%b%b%b%b want 00000", fl_if.fl_rd_en0,
                         fl_if.fl_rd_en1, fl_if.fl_wr_en0, fl_if.fl_wr_en1,
                         fl_if.fl_rollback_en);
    end
    checks++;
    if ({fl_if.ovf_err, fl_if.recovering} !== 2'b00) begin
      errors++; $display("FAIL reset_ovf_recov got %b%b want 00", fl_if.ovf_err,
                         fl_if.recovering);
    end
  endtask

  task automatic test_alloc_exhaust();
    for (int i = 0; i < 16; i++) begin
      drive(1, 1, 0, 0, 0, 6'd0, 6'd0, 0);
      checks++;
      if (fl_if.dp_stall !== 1'b0 || fl_if.fl_rd_en0 !== 1'b1 || fl_if.fl_rd_en1 !== 1'b1)
      begin
        errors++; $display("FAIL alloc_grant[%0d] stall=%b rd=%b%b want stall=0 rd=11", i,
                           fl_if.dp_stall, fl_if.fl_rd_en0, fl_if.fl_rd_en1);
      end
      tick();
      checks++;
      if (fl_if.free_cnt !== 6'(30 - 2 * i)) begin
        errors++; $display("FAIL alloc_cnt[%0d] got %0d want %0d", i, fl_if.free_cnt,
                           30 - 2 * i);
      end
    end
    drive(1, 1, 0, 0, 0, 6'd0, 6'd0, 0);
    checks++;
    if (fl_if.dp_stall !== 1'b1 || fl_if.fl_dp_stall !== 1'b1) begin
      errors++; $display("FAIL empty_stall got dp=%b fl=%b want 1 1", fl_if.dp_stall,
                         fl_if.fl_dp_stall);
    end
    drive(0, 0, 0, 0, 0, 6'd0, 6'd0, 0);
    checks++;
    if (fl_if.dp_stall !== 1'b0) begin
      errors++; $display("FAIL empty_no_need_stall got %b want 0", fl_if.dp_stall);
    end
  endtask

  task automatic test_no_partial();
    drive(0, 0, 0, 1, 0, 6'd5, 6'd0, 0);
    tick();
    checks++;
    if (fl_if.free_cnt !== 6'd1) begin
      errors++; $display("FAIL partial_setup_cnt got %0d want 1", fl_if.free_cnt);
    end
    drive(1, 1, 0, 1, 0, 6'd7, 6'd0, 0);
    checks++;
    if (fl_if.dp_stall !== 1'b1 || fl_if.fl_rd_en0 !== 1'b0 || fl_if.fl_rd_en1 !== 1'b0) begin
      errors++; $display("FAIL partial_stall stall=%b rd=%b%b want stall=1 rd=00",
                         fl_if.dp_stall, fl_if.fl_rd_en0, fl_if.fl_rd_en1);
    end
    checks++;
    if (fl_if.fl_wr_en0 !== 1'b1 || fl_if.fl_din0 !== 6'd7) begin
      errors++; $display("FAIL free_passthru wr=%b din=%0d want 1 7", fl_if.fl_wr_en0,
                         fl_if.fl_din0);
    end
    tick();
    checks++;
    if (fl_if.free_cnt !== 6'd2) begin
      errors++; $display("FAIL partial_cnt got %0d want 2", fl_if.free_cnt);
    end
    drive(1, 1, 0, 0, 0, 6'd0, 6'd0, 0);
    checks++;
    if (fl_if.dp_stall !== 1'b0 || fl_if.fl_rd_en1 !== 1'b1) begin
      errors++; $display("FAIL partial_regrant stall=%b rd1=%b want 0 1", fl_if.dp_stall,
                         fl_if.fl_rd_en1);
    end
    tick();
    checks++;
    if (fl_if.free_cnt !== 6'd0) begin
      errors++; $display("FAIL partial_final_cnt got %0d want 0", fl_if.free_cnt);
    end
  endtask

  task automatic test_squash();
    drive(1, 0, 0, 0, 0, 6'd0, 6'd0, 1);
    checks++;
    if (fl_if.dp_stall !== 1'b1 || fl_if.fl_rd_en0 !== 1'b0 || fl_if.fl_rollback_en !== 1'b0)
    begin
      errors++; $display("FAIL squash_t stall=%b rd0=%b rb=%b want 1 0 0", fl_if.dp_stall,
                         fl_if.fl_rd_en0, fl_if.fl_rollback_en);
    end
    tick();
    drive(1, 0, 0, 1, 0, 6'd9, 6'd0, 0);
    checks++;
    if (fl_if.fl_rollback_en !== 1'b1 || fl_if.fl_wr_en0 !== 1'b0 ||
        fl_if.dp_stall !== 1'b1 || fl_if.recovering !== 1'b1) begin
      errors++; $display("FAIL flush_t1 rb=%b wr0=%b stall=%b rec=%b want 1 0 1 1",
                         fl_if.fl_rollback_en, fl_if.fl_wr_en0, fl_if.dp_stall,
                         fl_if.recovering);
    end
    tick();
    drive(1, 0, 0, 0, 0, 6'd0, 6'd0, 0);
    checks++;
    if (fl_if.free_cnt !== 6'd32 || fl_if.fl_rollback_en !== 1'b0 ||
        fl_if.dp_stall !== 1'b1) begin
      errors++; $display("FAIL drain_t2 cnt=%0d rb=%b stall=%b want 32 0 1", fl_if.free_cnt,
                         fl_if.fl_rollback_en, fl_if.dp_stall);
    end
    tick();
    #2;
    checks++;
    if (fl_if.dp_stall !== 1'b1 || fl_if.recovering !== 1'b1) begin
      errors++; $display("FAIL drain_t3 stall=%b rec=%b want 1 1", fl_if.dp_stall,
                         fl_if.recovering);
    end
    tick();
    #2;
    checks++;
    if (fl_if.dp_stall !== 1'b0 || fl_if.fl_rd_en0 !== 1'b1 || fl_if.recovering !== 1'b0) begin
      errors++; $display("FAIL resume_t4 stall=%b rd0=%b rec=%b want 0 1 0", fl_if.dp_stall,
                         fl_if.fl_rd_en0, fl_if.recovering);
    end
    tick();
    checks++;
    if (fl_if.free_cnt !== 6'd31) begin
      errors++; $display("FAIL resume_cnt got %0d want 31", fl_if.free_cnt);
    end
  endtask

  task automatic test_overflow();
    drive(0, 0, 0, 1, 0, 6'd3, 6'd0, 0);
    tick();
    checks++;
    if (fl_if.free_cnt !== 6'd32 || fl_if.ovf_err !== 1'b0) begin
      errors++; $display("FAIL ovf_fill cnt=%0d ovf=%b want 32 0", fl_if.free_cnt,
                         fl_if.ovf_err);
    end
    drive(0, 0, 0, 1, 0, 6'd4, 6'd0, 0);
    tick();
    checks++;
    if (fl_if.free_cnt !== 6'd32 || fl_if.ovf_err !== 1'b1) begin
      errors++; $display("FAIL ovf_clamp cnt=%0d ovf=%b want 32 1", fl_if.free_cnt,
                         fl_if.ovf_err);
    end
    drive(0, 0, 0, 0, 0, 6'd0, 6'd0, 0);
    tick();
    tick();
    checks++;
    if (fl_if.ovf_err !== 1'b1) begin
      errors++; $display("FAIL ovf_sticky got %b want 1", fl_if.ovf_err);
    end
  endtask

  task automatic test_hold();
    for (int i = 0; i < 11; i++) begin
      drive(1, 1, 0, 0, 0, 6'd0, 6'd0, 0);
      tick();
    end
    checks++;
    if (fl_if.free_cnt !== 6'd10) begin
      errors++; $display("FAIL hold_setup_cnt got %0d want 10", fl_if.free_cnt);
    end
    drive(1, 1, 1, 0, 0, 6'd0, 6'd0, 0);
    checks++;
    if (fl_if.dp_stall !== 1'b1 || fl_if.fl_dp_stall !== 1'b1) begin
      errors++; $display("FAIL hold_stall dp=%b fl=%b want 1 1", fl_if.dp_stall,
                         fl_if.fl_dp_stall);
    end
    tick();
    checks++;
    if (fl_if.free_cnt !== 6'd10) begin
      errors++; $display("FAIL hold_cnt got %0d want 10", fl_if.free_cnt);
    end
    drive(1, 1, 0, 0, 0, 6'd0, 6'd0, 0);
    tick();
    checks++;
    if (fl_if.free_cnt !== 6'd8) begin
      errors++; $display("FAIL hold_release_cnt got %0d want 8", fl_if.free_cnt);
    end
  endtask

  task automatic test_resquash_and_async_reset();
    drive(0, 0, 0, 0, 0, 6'd0, 6'd0, 1);
    tick();
    drive(0, 0, 0, 0, 0, 6'd0, 6'd0, 1);
    tick();
    drive(0, 0, 0, 0, 0, 6'd0, 6'd0, 0);
    checks++;
    if (fl_if.fl_rollback_en !== 1'b1) begin
      errors++; $display("FAIL resquash_flush rb=%b want 1", fl_if.fl_rollback_en);
    end
    tick();
    drive(0, 0, 0, 0, 0, 6'd0, 6'd0, 1);
    checks++;
    if (fl_if.fl_rollback_en !== 1'b0 || fl_if.free_cnt !== 6'd32) begin
      errors++; $display("FAIL resquash_drain rb=%b cnt=%0d want 0 32", fl_if.fl_rollback_en,
                         fl_if.free_cnt);
    end
    tick();
    drive(0, 0, 0, 0, 0, 6'd0, 6'd0, 0);
    checks++;
    if (fl_if.fl_rollback_en !== 1'b1) begin
      errors++; $display("FAIL drain_squash_reflush rb=%b want 1", fl_if.fl_rollback_en);
    end
    reset = 1'b0;
    #1;
    checks++;
    if (fl_if.recovering !== 1'b0 || fl_if.fl_rollback_en !== 1'b0 ||
        fl_if.ovf_err !== 1'b0) begin
      errors++; $display("FAIL async_reset rec=%b rb=%b ovf=%b want 0 0 0", fl_if.recovering,
                         fl_if.fl_rollback_en, fl_if.ovf_err);
    end
    tick();
    reset = 1'b1;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_alloc_exhaust();
    test_no_partial();
    test_squash();
    test_overflow();
    test_hold();
    test_resquash_and_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
